product_requant: RTL and testbench
==================================

# product_requant

Downstream stage of the 16×16 signed Booth multiplier.
- Takes the signed 32-bit product.
- Drops a run-time-selectable number of fraction bits with round-half-up.
- Saturates (or wraps) the result to 16 bits and delivers it over a valid/ready stream to the audio path.
- Two-stage pipeline, full throughput, sticky saturation statistics for gain/volume debugging.

## Interface
Parameters:
- PROD_W, 32, product width (must match multiplier output)
- OUT_W, 16, output sample width
- SHIFT_W, 4, width of shift control (shift range 0..15)
- CNT_W, 16, saturation counter width

Ports:
- clk_i  in  1  clock; all state on rising edge
- rst_ni  in  1  reset, asynchronous assert, active-low
- prod_i  in  PROD_W  signed product
- shift_i  in  SHIFT_W  fraction bits to drop; sampled with the product beat
- sat_en_i  in  1  1 = saturate, 0 = wrap; sampled with the product beat
- prod_valid_i  in  1  input beat valid
- prod_ready_o  out  1  block accepts input this cycle
- out_o  out  OUT_W  signed result
- sat_flag_o  out  1  this output beat was out of range; aligned with out_o
- out_valid_o  out  1  output beat valid
- out_ready_i  in  1  consumer accepts output
- sat_count_o  out  CNT_W  count of delivered out-of-range beats, sticks at all-ones
- clr_count_i  in  1  synchronous clear of sat_count_o

## Operation
- Input handshake: a beat is taken when prod_valid_i && prod_ready_o. Output handshake: a beat is delivered when out_valid_o && out_ready_i.
- S1 (round), on accept:
  - Sign-extend the product to PROD_W+1 bits.
  - If shift ≠ 0, add 2^(shift−1).
  - Arithmetic right shift by shift.
  - Store the result with sat_en.
- S2 (limit):
  - If the S1 value is outside [−2^(OUT_W−1), 2^(OUT_W−1)−1], set sat_flag = 1.
  - If sat_en = 1 and sat_flag = 1: out = clamp to the nearest bound.
  - If sat_en = 0: out = low OUT_W bits (wrap). sat_flag is still reported.
- Ordering: strictly in order; no beat is dropped or duplicated under any backpressure pattern.
- Counter update, evaluated each cycle:
  - clr_count_i = 1: counter goes to 0. Clear wins over a simultaneous increment.
  - Otherwise: increment on an output handshake with sat_flag_o = 1, saturating at 2^CNT_W−1.
- Reset mid-operation discards all in-flight beats. No partial output.

## Timing
- Latency: 2 cycles from input handshake to out_valid_o, with out_ready_i held high.
- Throughput: 1 beat/cycle sustained.
- Each stage holds a valid bit.
  - S2 loads when !out_valid_o || out_ready_i.
  - S1 loads when !s1_valid || S2 loads.
  - prod_ready_o = !s1_valid || S2 loads. It is combinational from out_ready_i; this is the only comb path through the block.
- Capacity: with out_ready_i low, the block accepts exactly 2 beats, then prod_ready_o = 0.
- Stability: out_o and sat_flag_o stay stable while out_valid_o && !out_ready_i.
- Reset values: out_o = 0, sat_flag_o = 0, out_valid_o = 0, sat_count_o = 0, both stage valids = 0.
  - prod_ready_o = 1 during and after reset, since the pipe is empty.
- The first input beat can be accepted on the first clock edge after rst_ni deasserts.

## Structure
- Package requant_pkg:
  - Width constants PROD_W, OUT_W, SHIFT_W, CNT_W.
  - Typedefs prod_t, wide_t (PROD_W+1), sample_t.
  - Pure functions round_shift(wide_t, shift) and limit(wide_t, sat_en, out sample_t, out flag).
- Sub-module rs_stage: generic valid/ready register slice parameterised on payload type, instantiated twice (S1, S2).
- Top level holds the arithmetic between the slices and the saturation counter.

## Test plan
- Rounding:
  - shift=15, prod=0x0000_C000 → out=2, flag=0.
  - prod=0xFFFF_4000 (−49152) → out=−1, flag=0 (half rounds up).
- Saturation:
  - shift=15, prod=0x4000_0000, sat_en=1 → out=0x7FFF, flag=1.
  - prod=0x8000_0000 → out=0x8000, flag=1. sat_count_o ends at 2.
- Wrap: shift=0, prod=0x0001_2345, sat_en=0 → out=0x2345, flag=1, count+1.
- Backpressure:
  - Setup: out_ready_i=0, present 5 beats back-to-back.
  - prod_ready_o drops after 2 accepted and out_o is held stable.
  - Release out_ready_i: all 5 delivered in order, 1/cycle, none lost.
- Counter:
  - Preload by 65535 saturating beats: sat_count_o=0xFFFF, stays 0xFFFF on further hits.
  - clr_count_i together with a hit → 0.
- Reset: assert rst_ni low with 2 beats in flight → out_valid_o=0 immediately (async), no stale beat after release, prod_ready_o=1.

Source files
------------

// File: rtl/product_requant_pkg.sv
// Shared widths, payload types and the round/limit arithmetic for the product requantiser.
package requant_pkg;

  localparam int PROD_W  = 32;
  localparam int OUT_W   = 16;
  localparam int SHIFT_W = 4;
  localparam int CNT_W   = 16;

  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [PROD_W:0]   wide_t;
  typedef logic signed [OUT_W-1:0]  sample_t;
  typedef logic        [SHIFT_W-1:0] shift_t;
  typedef logic        [CNT_W-1:0]  count_t;

  typedef struct packed {
    wide_t value;
    logic  sat_en;
  } s1_t;

  typedef struct packed {
    sample_t sample;
    logic    sat_flag;
  } s2_t;

  localparam wide_t SAMPLE_MAX = wide_t'((2 ** (OUT_W - 1)) - 1);
  localparam wide_t SAMPLE_MIN = wide_t'(-(2 ** (OUT_W - 1)));

  // The extra MSB of wide_t absorbs the rounding bias, so the add never overflows.
  function automatic wide_t round_shift(input wide_t value, input shift_t shift);
    wide_t bias;
    wide_t sum;
    bias = (shift == '0) ? '0 : (wide_t'(1) << (shift - 1'b1));
    sum  = value + bias;
    return sum >>> shift;
  endfunction

  function automatic void limit(input wide_t value, input logic sat_en,
                                output sample_t sample, output logic flag);
    flag = (value > SAMPLE_MAX) || (value < SAMPLE_MIN);
    if (sat_en && flag)
      sample = (value < 0) ? sample_t'(SAMPLE_MIN[OUT_W-1:0]) : sample_t'(SAMPLE_MAX[OUT_W-1:0]);
    else
      sample = value[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/product_requant_if.sv
// Product-in / sample-out stream bundle plus saturation statistics.
interface requant_if;
  import requant_pkg::*;

  prod_t   prod_i;
  shift_t  shift_i;
  logic    sat_en_i;
  logic    prod_valid_i;
  logic    prod_ready_o;
  sample_t out_o;
  logic    sat_flag_o;
  logic    out_valid_o;
  logic    out_ready_i;
  count_t  sat_count_o;
  logic    clr_count_i;

  modport master (
    output prod_i, shift_i, sat_en_i, prod_valid_i, out_ready_i, clr_count_i,
    input  prod_ready_o, out_o, sat_flag_o, out_valid_o, sat_count_o
  );

  modport slave (
    input  prod_i, shift_i, sat_en_i, prod_valid_i, out_ready_i, clr_count_i,
    output prod_ready_o, out_o, sat_flag_o, out_valid_o, sat_count_o
  );
endinterface

// File: rtl/product_requant_rs_stage.sv
// Generic valid/ready register slice; ready is combinational from the downstream ready.
module rs_stage #(
  parameter type T = logic
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  output logic in_ready,
  input  T     in_data,
  output logic out_valid,
  input  logic out_ready,
  output T     out_data
);

  assign in_ready = !out_valid || out_ready;

  // Payload only moves on a real beat so outputs stay quiet while idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid)
        out_data <= in_data;
    end
  end

endmodule

// File: rtl/product_requant.sv
// Two-stage round/limit pipeline from the 32-bit multiplier product to 16-bit audio samples.
module product_requant
  import requant_pkg::*;
#(
  parameter int PROD_W  = requant_pkg::PROD_W,
  parameter int OUT_W   = requant_pkg::OUT_W,
  parameter int SHIFT_W = requant_pkg::SHIFT_W,
  parameter int CNT_W   = requant_pkg::CNT_W
) (
  input logic      clk_i,
  input logic      rst_ni,
  requant_if.slave bus
);

  if (PROD_W != requant_pkg::PROD_W || OUT_W != requant_pkg::OUT_W ||
      SHIFT_W != requant_pkg::SHIFT_W || CNT_W != requant_pkg::CNT_W) begin : g_param_check
    $error("product_requant parameters must match requant_pkg");
  end

  s1_t     s1_in, s1_data;
  s2_t     s2_in, s2_data;
  logic    s1_valid, s2_ready, s2_valid;
  sample_t lim_sample;
  logic    lim_flag;
  count_t  sat_count;

  assign s1_in.value  = round_shift(wide_t'(bus.prod_i), bus.shift_i);
  assign s1_in.sat_en = bus.sat_en_i;

  rs_stage #(.T(s1_t)) u_s1 (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .in_valid  (bus.prod_valid_i),
    .in_ready  (bus.prod_ready_o),
    .in_data   (s1_in),
    .out_valid (s1_valid),
    .out_ready (s2_ready),
    .out_data  (s1_data)
  );

  always_comb begin
    lim_sample = '0;
    lim_flag   = 1'b0;
    limit(s1_data.value, s1_data.sat_en, lim_sample, lim_flag);
  end

  assign s2_in.sample   = lim_sample;
  assign s2_in.sat_flag = lim_flag;

  rs_stage #(.T(s2_t)) u_s2 (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .in_valid  (s1_valid),
    .in_ready  (s2_ready),
    .in_data   (s2_in),
    .out_valid (s2_valid),
    .out_ready (bus.out_ready_i),
    .out_data  (s2_data)
  );

  // Counts only delivered out-of-range beats; clear beats a same-cycle hit.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      sat_count <= '0;
    else if (bus.clr_count_i)
      sat_count <= '0;
    else if (s2_valid && bus.out_ready_i && s2_data.sat_flag && sat_count != '1)
      sat_count <= sat_count + 1'b1;
  end

  assign bus.out_o       = s2_data.sample;
  assign bus.sat_flag_o  = s2_data.sat_flag;
  assign bus.out_valid_o = s2_valid;
  assign bus.sat_count_o = sat_count;

endmodule

// File: tb/tb_product_requant.sv
// Directed self-checking bench for product_requant: rounding, saturation, wrap,
// backpressure, counter stickiness/clear and asynchronous reset.
module tb_product_requant;
  import requant_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   failures = 0;

  requant_if bus ();

  product_requant dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // One beat with out_ready high; checks the exact two-cycle latency and the result.
  task automatic applyStimulus(input string tag, input logic [31:0] prod, input logic [3:0] shift,
                               input logic sat_en, input logic [15:0] exp_out, input logic exp_flag);
    @(negedge clk);
    bus.prod_i       = prod;
    bus.shift_i      = shift;
    bus.sat_en_i     = sat_en;
    bus.prod_valid_i = 1'b1;
    bus.out_ready_i  = 1'b1;
    #1;
    checkOutput({tag, "_in_ready"}, {31'b0, bus.prod_ready_o}, 32'd1);
    @(posedge clk);
    #1 bus.prod_valid_i = 1'b0;
    @(negedge clk);
    checkOutput({tag, "_early"}, {31'b0, bus.out_valid_o}, 32'd0);
    @(negedge clk);
    checkOutput({tag, "_valid"}, {31'b0, bus.out_valid_o}, 32'd1);
    checkOutput({tag, "_out"}, {16'b0, bus.out_o}, {16'b0, exp_out});
    checkOutput({tag, "_flag"}, {31'b0, bus.sat_flag_o}, {31'b0, exp_flag});
  endtask

  initial begin
    int idx, nrecv, first_cyc, last_cyc, accepted, stale;

    rst_n            = 1'b0;
    bus.prod_i       = '0;
    bus.shift_i      = '0;
    bus.sat_en_i     = 1'b1;
    bus.prod_valid_i = 1'b0;
    bus.out_ready_i  = 1'b1;
    bus.clr_count_i  = 1'b0;

    repeat (3) @(negedge clk);
    checkOutput("rst_valid", {31'b0, bus.out_valid_o}, 32'd0);
    checkOutput("rst_out", {16'b0, bus.out_o}, 32'd0);
    checkOutput("rst_flag", {31'b0, bus.sat_flag_o}, 32'd0);
    checkOutput("rst_count", {16'b0, bus.sat_count_o}, 32'd0);
    checkOutput("rst_ready", {31'b0, bus.prod_ready_o}, 32'd1);
    rst_n = 1'b1;

    applyStimulus("round_pos", 32'h0000_C000, 4'd15, 1'b1, 16'h0002, 1'b0);
    applyStimulus("round_neg", 32'hFFFF_4000, 4'd15, 1'b1, 16'hFFFF, 1'b0);
    applyStimulus("sat_pos", 32'h4000_0000, 4'd15, 1'b1, 16'h7FFF, 1'b1);
    applyStimulus("sat_neg", 32'h8000_0000, 4'd15, 1'b1, 16'h8000, 1'b1);
    @(negedge clk);
    checkOutput("count_two", {16'b0, bus.sat_count_o}, 32'd2);
    applyStimulus("wrap", 32'h0001_2345, 4'd0, 1'b0, 16'h2345, 1'b1);
    @(negedge clk);
    checkOutput("count_three", {16'b0, bus.sat_count_o}, 32'd3);
    applyStimulus("max_exact", 32'h0000_7FFF, 4'd0, 1'b1, 16'h7FFF, 1'b0);
    applyStimulus("half_to_zero", 32'hFFFF_FFF8, 4'd4, 1'b1, 16'h0000, 1'b0);
    applyStimulus("half_up_pos", 32'h0000_0003, 4'd1, 1'b1, 16'h0002, 1'b0);
    applyStimulus("half_up_neg", 32'hFFFF_FFFD, 4'd1, 1'b1, 16'hFFFF, 1'b0);

    // Five beats against a stalled consumer, released at cycle 6.
    idx = 0; nrecv = 0; first_cyc = -1; last_cyc = -1;
    bus.shift_i  = 4'd0;
    bus.sat_en_i = 1'b1;
    for (int cyc = 0; cyc < 25; cyc++) begin
      @(negedge clk);
      bus.out_ready_i  = (cyc >= 6);
      bus.prod_valid_i = (idx < 5);
      bus.prod_i       = 32'h10 + idx;
      #1;
      if (cyc == 5) begin
        checkOutput("bp_accepted", idx, 32'd2);
        checkOutput("bp_ready_low", {31'b0, bus.prod_ready_o}, 32'd0);
        checkOutput("bp_hold_valid", {31'b0, bus.out_valid_o}, 32'd1);
        checkOutput("bp_hold_out", {16'b0, bus.out_o}, 32'h10);
      end
      if (bus.out_valid_o && bus.out_ready_i) begin
        checkOutput("bp_order", {16'b0, bus.out_o}, 32'h10 + nrecv);
        if (nrecv == 0) first_cyc = cyc;
        last_cyc = cyc;
        nrecv++;
      end
      if (bus.prod_valid_i && bus.prod_ready_o) idx++;
    end
    bus.prod_valid_i = 1'b0;
    checkOutput("bp_received", nrecv, 32'd5);
    checkOutput("bp_throughput", last_cyc - first_cyc, 32'd4);
    checkOutput("bp_count_same", {16'b0, bus.sat_count_o}, 32'd3);

    @(negedge clk);
    bus.clr_count_i = 1'b1;
    @(negedge clk);
    bus.clr_count_i = 1'b0;
    checkOutput("clear_idle", {16'b0, bus.sat_count_o}, 32'd0);

    // Stream enough saturating beats to fill the counter.
    accepted = 0;
    bus.prod_i      = 32'h4000_0000;
    bus.out_ready_i = 1'b1;
    for (int cyc = 0; cyc < 70000 && accepted < 65535; cyc++) begin
      @(negedge clk);
      bus.prod_valid_i = 1'b1;
      #1;
      if (bus.prod_ready_o) accepted++;
    end
    @(posedge clk);
    #1 bus.prod_valid_i = 1'b0;
    checkOutput("preload_accepted", accepted, 32'd65535);
    repeat (3) @(negedge clk);
    checkOutput("count_full", {16'b0, bus.sat_count_o}, 32'hFFFF);
    applyStimulus("stick_hit", 32'h4000_0000, 4'd0, 1'b1, 16'h7FFF, 1'b1);
    @(negedge clk);
    checkOutput("count_sticks", {16'b0, bus.sat_count_o}, 32'hFFFF);

    // Clear lands in the same cycle as a delivered saturating beat.
    @(negedge clk);
    bus.prod_i = 32'h4000_0000; bus.prod_valid_i = 1'b1;
    @(posedge clk);
    #1 bus.prod_valid_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("clr_hit_valid", {31'b0, bus.out_valid_o & bus.sat_flag_o}, 32'd1);
    bus.clr_count_i = 1'b1;
    @(posedge clk);
    #1 bus.clr_count_i = 1'b0;
    @(negedge clk);
    checkOutput("clear_wins", {16'b0, bus.sat_count_o}, 32'd0);
    applyStimulus("after_clear", 32'h8000_0000, 4'd0, 1'b1, 16'h8000, 1'b1);
    @(negedge clk);
    checkOutput("count_one", {16'b0, bus.sat_count_o}, 32'd1);

    // Two beats in flight, then asynchronous reset between edges.
    @(negedge clk);
    bus.out_ready_i  = 1'b0;
    bus.prod_i       = 32'h100;
    bus.prod_valid_i = 1'b1;
    @(posedge clk);
    #1 bus.prod_i = 32'h101;
    @(posedge clk);
    #1 bus.prod_valid_i = 1'b0;
    @(negedge clk);
    checkOutput("pre_rst_valid", {31'b0, bus.out_valid_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_valid", {31'b0, bus.out_valid_o}, 32'd0);
    checkOutput("arst_ready", {31'b0, bus.prod_ready_o}, 32'd1);
    checkOutput("arst_out", {16'b0, bus.out_o}, 32'd0);
    checkOutput("arst_count", {16'b0, bus.sat_count_o}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready_i = 1'b1;
    stale = 0;
    repeat (5) begin
      @(negedge clk);
      if (bus.out_valid_o) stale++;
    end
    checkOutput("no_stale", stale, 32'd0);
    applyStimulus("post_rst", 32'h0000_4000, 4'd14, 1'b1, 16'h0001, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
